// File: rtl/mmio_responder.sv
// Memory-mapped peripheral block: GPIO out/in, a compare/match timer and a
// scratch register. Read data is registered, so it has the same latency as a sync RAM.
module mmio_responder #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int GPIO_W = 8
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] ddata_w,
    input  logic              d_rw,
    input  logic              sel,
    output logic [DATA_W-1:0] ddata_r,
    input  logic [GPIO_W-1:0] gpio_in,
    output logic [GPIO_W-1:0] gpio_out,
    output logic              irq
);

    localparam logic [2:0] A_GPIO_OUT = 3'd0;
    localparam logic [2:0] A_GPIO_IN  = 3'd1;
    localparam logic [2:0] A_TCNT     = 3'd2;
    localparam logic [2:0] A_TCMP     = 3'd3;
    localparam logic [2:0] A_CTRL     = 3'd4;
    localparam logic [2:0] A_STATUS   = 3'd5;
    localparam logic [2:0] A_SCRATCH  = 3'd6;

    localparam logic [DATA_W-1:0] TCNT_ONE = DATA_W'(1);

    logic [GPIO_W-1:0] gpio_q;
    logic [GPIO_W-1:0] sync1, sync2;
    logic [DATA_W-1:0] tcnt, tcmp, scratch;
    logic [2:0]        ctrl;
    logic              match;
    logic [DATA_W-1:0] rdata;

    logic [2:0] reg_sel;
    logic       wr_en, rd_en, en, ie, ar, hit;
    logic       unused_addr_hi;

    assign reg_sel        = daddr[2:0];
    assign unused_addr_hi = ^daddr[ADDR_W-1:3];
    assign wr_en          = sel & ~d_rw;
    assign rd_en          = sel & d_rw;
    assign en             = ctrl[0];
    assign ie             = ctrl[1];
    assign ar             = ctrl[2];
    assign hit            = en & (tcnt == tcmp);

    assign gpio_out = gpio_q;
    assign irq      = match & ie;

    // Read mux sees pre-edge register values, so a TCNT read returns the count
    // before this edge's increment.
    always_comb begin
        rdata = '0;
        case (reg_sel)
            A_GPIO_OUT: rdata[GPIO_W-1:0] = gpio_q;
            A_GPIO_IN:  rdata[GPIO_W-1:0] = sync2;
            A_TCNT:     rdata             = tcnt;
            A_TCMP:     rdata             = tcmp;
            A_CTRL:     rdata[2:0]        = ctrl;
            A_STATUS:   rdata[0]          = match;
            A_SCRATCH:  rdata             = scratch;
            default:    rdata             = '0;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            gpio_q  <= '0;
            tcmp    <= '0;
            ctrl    <= '0;
            scratch <= '0;
        end else if (wr_en) begin
            case (reg_sel)
                A_GPIO_OUT: gpio_q  <= ddata_w[GPIO_W-1:0];
                A_TCMP:     tcmp    <= ddata_w;
                A_CTRL:     ctrl    <= ddata_w[2:0];
                A_SCRATCH:  scratch <= ddata_w;
                default:    ;
            endcase
        end
    end

    // Software write to TCNT beats both increment and auto-reload.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            tcnt <= '0;
        end else if (wr_en && reg_sel == A_TCNT) begin
            tcnt <= ddata_w;
        end else if (en) begin
            tcnt <= (hit && ar) ? '0 : tcnt + TCNT_ONE;
        end
    end

    // A match on the same edge as a W1C keeps MATCH set.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            match <= 1'b0;
        end else if (hit) begin
            match <= 1'b1;
        end else if (wr_en && reg_sel == A_STATUS && ddata_w[0]) begin
            match <= 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= gpio_in;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ddata_r <= '0;
        end else if (rd_en) begin
            ddata_r <= rdata;
        end
    end

endmodule

// File: tb/tb_mmio_responder.sv
// Directed bench for mmio_responder: register map, GPIO sync latency, timer
// match/reload/wrap, W1C priority and asynchronous reset.
module tb_mmio_responder;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic [9:0]  daddr;
    logic [31:0] ddata_w;
    logic        d_rw;
    logic        sel;
    logic [31:0] ddata_r;
    logic [7:0]  gpio_in;
    logic [7:0]  gpio_out;
    logic        irq;

    int checks   = 0;
    int failures = 0;
    logic [31:0] d;

    mmio_responder #(.ADDR_W(10), .DATA_W(32), .GPIO_W(8)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .daddr(daddr), .ddata_w(ddata_w),
        .d_rw(d_rw), .sel(sel), .ddata_r(ddata_r), .gpio_in(gpio_in),
        .gpio_out(gpio_out), .irq(irq)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called at a negedge; occupies exactly one rising edge. Upper address bits
    // carry junk to show they are ignored.
    task automatic wr(input logic [2:0] a, input logic [31:0] v);
        sel = 1'b1; d_rw = 1'b0; daddr = {7'h55, a}; ddata_w = v;
        @(negedge CLK);
        sel = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] v);
        sel = 1'b1; d_rw = 1'b1; daddr = {7'h2A, a}; ddata_w = 32'hFFFF_FFFF;
        @(negedge CLK);
        sel = 1'b0;
        v = ddata_r;
    endtask

    initial begin
        RESET_N = 1'b0; sel = 1'b0; d_rw = 1'b1; daddr = '0; ddata_w = '0; gpio_in = '0;
        #1;
        check("rst_gpio_out", 32'(gpio_out), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_ddata_r", ddata_r, 32'h0);
        repeat (2) @(negedge CLK);
        RESET_N = 1'b1;

        for (int i = 0; i < 8; i++) begin
            rd(3'(i), d);
            check($sformatf("rst_read_a%0d", i), d, 32'h0);
        end

        // Register map basics
        wr(3'd0, 32'hFFFF_FFA5);
        wr(3'd6, 32'hDEAD_BEEF);
        check("gpio_out_a5", 32'(gpio_out), 32'hA5);
        rd(3'd0, d); check("rd_gpio_out", d, 32'h0000_00A5);
        rd(3'd6, d); check("rd_scratch", d, 32'hDEAD_BEEF);
        wr(3'd7, 32'h1234_5678);
        rd(3'd7, d); check("rd_reserved", d, 32'h0);
        wr(3'd4, 32'hFFFF_FFFE);
        rd(3'd4, d); check("rd_ctrl_narrow", d, 32'h6);
        wr(3'd1, 32'hFF);
        rd(3'd1, d); check("gpio_in_ro", d, 32'h0);

        // GPIO synchronizer: two-edge latency
        gpio_in = 8'h3C;
        @(negedge CLK);
        rd(3'd1, d); check("gpio_in_t1", d, 32'h00);
        rd(3'd1, d); check("gpio_in_t2", d, 32'h3C);

        // Timer match with auto-reload and interrupt
        wr(3'd3, 32'd5);
        wr(3'd4, 32'b111);
        check("irq_pre", 32'(irq), 32'h0);
        repeat (5) @(negedge CLK);
        check("irq_edge5", 32'(irq), 32'h0);
        @(negedge CLK);
        check("irq_edge6", 32'(irq), 32'h1);
        rd(3'd2, d); check("tcnt_reload", d, 32'h0);
        wr(3'd5, 32'h1);
        check("irq_w1c", 32'(irq), 32'h0);
        rd(3'd5, d); check("status_cleared", d, 32'h0);
        wr(3'd4, 32'h0);
        rd(3'd2, d); check("tcnt_stop", d, 32'd4);
        repeat (3) @(negedge CLK);
        rd(3'd2, d); check("tcnt_frozen", d, 32'd4);

        // Wrap without auto-reload; TCNT write beats increment
        wr(3'd3, 32'd3);
        wr(3'd4, 32'b001);
        wr(3'd2, 32'hFFFF_FFFF);
        rd(3'd2, d); check("tcnt_ffff", d, 32'hFFFF_FFFF);
        rd(3'd2, d); check("tcnt_wrap0", d, 32'h0);
        rd(3'd2, d); check("tcnt_1", d, 32'h1);
        rd(3'd2, d); check("tcnt_2", d, 32'h2);
        rd(3'd5, d); check("status_at_3", d, 32'h0);
        rd(3'd2, d); check("tcnt_after_match", d, 32'h4);
        rd(3'd5, d); check("status_match", d, 32'h1);
        check("irq_ie0", 32'(irq), 32'h0);
        wr(3'd5, 32'h0);
        rd(3'd5, d); check("status_w0_keep", d, 32'h1);
        wr(3'd5, 32'h1);
        rd(3'd5, d); check("status_w1c", d, 32'h0);

        // W1C on the same edge as a match: set wins
        wr(3'd4, 32'h0);
        wr(3'd2, 32'h0);
        wr(3'd3, 32'd2);
        wr(3'd4, 32'b011);
        repeat (2) @(negedge CLK);
        wr(3'd5, 32'h1);
        check("irq_set_wins", 32'(irq), 32'h1);
        rd(3'd5, d); check("status_set_wins", d, 32'h1);

        // Asynchronous reset mid-count
        #2;
        RESET_N = 1'b0;
        #1;
        check("arst_gpio_out", 32'(gpio_out), 32'h0);
        check("arst_irq", 32'(irq), 32'h0);
        check("arst_ddata_r", ddata_r, 32'h0);
        repeat (2) @(negedge CLK);
        RESET_N = 1'b1;
        repeat (3) @(negedge CLK);
        rd(3'd2, d); check("post_rst_tcnt", d, 32'h0);
        rd(3'd4, d); check("post_rst_ctrl", d, 32'h0);
        rd(3'd6, d); check("post_rst_scratch", d, 32'h0);
        rd(3'd0, d); check("post_rst_gpio", d, 32'h0);
        rd(3'd2, d); check("post_rst_tcnt_frozen", d, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mmio_responder.md
MMIO_RESPONDER -- requirements
Module: mmio_responder

Interface
REQ-001 SHALL have parameters: ADDR_W, default 10, data-bus word address width; DATA_W, default 32, data word width; GPIO_W, default 8, GPIO pin count.
REQ-002 SHALL have port CLK, input, 1, sole clock; all state changes on its rising edge.
REQ-003 SHALL have port RESET_N, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port daddr, input, ADDR_W, core data word address; bits [2:0] select the register and the upper bits are ignored.
REQ-005 SHALL have port ddata_w, input, DATA_W, core store data.
REQ-006 SHALL have port d_rw, input, 1, 1 = read, 0 = write (core data-port convention).
REQ-007 SHALL have port sel, input, 1, chip select from the system address decoder.
REQ-008 SHALL have port ddata_r, output, DATA_W, registered read data.
REQ-009 SHALL have port gpio_in, input, GPIO_W, asynchronous external inputs.
REQ-010 SHALL have port gpio_out, output, GPIO_W, registered outputs.
REQ-011 SHALL have port irq, output, 1, timer interrupt request.

Function
REQ-012 Register map, by daddr[2:0]:
- 0 = GPIO_OUT, RW.
- 1 = GPIO_IN, RO.
- 2 = TCNT, RW.
- 3 = TCMP, RW.
- 4 = CTRL, RW bits [2:0]: bit0 EN, bit1 IE, bit2 AR (auto-reload).
- 5 = STATUS, bit0 MATCH, write-1-to-clear.
- 6 = SCRATCH, RW.
- 7 = reserved; reads 0, writes ignored.
REQ-013 Write SHALL occur at the rising edge where sel=1 and d_rw=0; RO and reserved targets ignore writes.
REQ-014 Read: at an edge with sel=1 and d_rw=1, ddata_r SHALL load the addressed register value (read latency one cycle, matching synchronous RAM); otherwise ddata_r holds.
REQ-015 Narrow registers SHALL read zero-extended to DATA_W; writes SHALL use the low bits of ddata_w only.
REQ-016 gpio_in SHALL pass a 2-flop synchronizer; GPIO_IN returns the second-stage value, so a pin change is visible to a read issued 2 cycles later.
REQ-017 gpio_out SHALL equal GPIO_OUT[GPIO_W-1:0] directly.
REQ-018 TCNT SHALL be DATA_W wide; when EN=1 it increments by 1 per cycle, wrapping from all-ones to 0.
REQ-019 Match: when EN=1 and TCNT==TCMP, the next edge SHALL set MATCH and load TCNT with 0 if AR=1, else TCNT+1.
REQ-020 A TCNT write SHALL take priority over increment and reload in the same cycle.
REQ-021 When MATCH is set and a W1C of bit0 occur in the same cycle, set SHALL win.
REQ-022 A STATUS write with bit0=0 SHALL leave MATCH unchanged.
REQ-023 irq SHALL be MATCH AND IE, combinational from registers with no input-to-output path.
REQ-024 EN=0 SHALL freeze TCNT; MATCH SHALL NOT be set while EN=0.
REQ-025 A read of TCNT SHALL return the pre-edge value, i.e. the count before the increment at that edge.

Reset
REQ-026 RESET_N low SHALL asynchronously clear to 0: all registers, both synchronizer stages, ddata_r, gpio_out, and irq.
REQ-027 Reset asserted mid-count or mid-access SHALL abort the operation; after release the block is idle with EN=0.
REQ-028 Deassertion is synchronized externally; the block SHALL accept an access on the first edge after release.

Verification
REQ-029 Reset then read all 8 addresses -> ddata_r=0 each read, one cycle after the request; gpio_out=0; irq=0.
REQ-030 Write GPIO_OUT=0xA5, SCRATCH=0xDEADBEEF, then read both -> gpio_out=0xA5; reads return 0x000000A5 and 0xDEADBEEF; a write to addr 7 followed by a read of addr 7 returns 0.
REQ-031 gpio_in changes 0x00->0x3C at cycle t, GPIO_IN read at t+1 -> ddata_r 0x00; read at t+2 -> 0x3C.
REQ-032 TCMP=5, CTRL=0b111 -> MATCH set and irq=1 six cycles after EN; TCNT reads 0 the cycle after the match; W1C STATUS drops irq the next cycle.
REQ-033 Write TCNT=0xFFFFFFFF with EN=1, AR=0, TCMP=3 -> TCNT wraps to 0, MATCH sets when TCNT=3, and TCNT continues to 4.
REQ-034 W1C STATUS issued on the same edge a match occurs -> MATCH remains 1; RESET_N pulsed low mid-count -> all outputs 0 immediately and TCNT frozen at 0.
